// File: rtl/popcnt_seq.sv
// Purpose: 48-bit population count, one shared 12-bit counter stepped over four chunks.
// Latency: four RUN edges after acceptance. With POPCNT_SEQ_ZERO_SKIP_EN, it is 0 to 4 edges and stops once the remaining bits are zero.
// Backpressure: one word in flight. in_ready only in IDLE; the result holds in DONE until out_ready.

// Counts the ones in one 12-bit chunk and reports the count as a one-hot vector.
// Bit n of 'onehot' is set when the count is n.
module popcnt12 (
    input  logic [11:0] data,
    output logic [12:0] onehot
);

    logic [3:0] cnt;

    // Plain adder-tree count, then decode to one-hot.
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 12; i++) begin
            cnt = cnt + {3'b000, data[i]};
        end
        onehot = 13'b1 << cnt;
    end

endmodule

module popcnt_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_cnt,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q,   idx_d;
    logic [47:0] sreg_q,  sreg_d;
    logic [5:0]  acc_q,   acc_d;

    logic [12:0] chunk_onehot;
    logic [3:0]  chunk_bin;

    // The single shared counter always looks at the low chunk of the shift register.
    popcnt12 u_popcnt12 (
        .data   (sreg_q[11:0]),
        .onehot (chunk_onehot)
    );

    // One-hot to binary: OR together the indices of the set bits.
    // Only one bit is set, so the result is exactly that bit's index.
    always_comb begin
        chunk_bin = 4'd0;
        for (int n = 0; n < 13; n++) begin
            if (chunk_onehot[n]) begin
                chunk_bin = chunk_bin | 4'(n);
            end
        end
    end

    // State and datapath registers. Reset wins over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            sreg_q  <= 48'd0;
            acc_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state and datapath updates. Registers hold by default.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d = in_data;
                    acc_d  = 6'd0;
                    idx_d  = 2'd0;
`ifdef POPCNT_SEQ_ZERO_SKIP_EN
                    // An all-zero word has count 0, so skip straight to the result.
                    state_d = (in_data == 48'd0) ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end

            RUN: begin
                // The largest sum is 4 * 12 = 48, which fits in 6 bits.
                acc_d  = acc_q + {2'b00, chunk_bin};
                sreg_d = {12'd0, sreg_q[47:12]};
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end
`ifdef POPCNT_SEQ_ZERO_SKIP_EN
                // No ones are left in the remaining chunks, so the count is final.
                else if (sreg_d == 48'd0) begin
                    state_d = DONE;
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from registered state only, so no input reaches them combinationally.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_cnt   = acc_q;
    end

endmodule
